// File: rtl/imsic_msi_arbiter_pkg.sv
// ============================================================================
// Module      : imsic_msi_arbiter_pkg
// Description : IMSIC configuration, MSI request/channel types and FSM states
//               shared by the MSI arbiter and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imsic_msi_arbiter_pkg;

    typedef struct packed {
        int unsigned NrHarts;
        int unsigned NrSources;
        int unsigned NrInptFiles;
    } imsic_cfg_t;

    localparam imsic_cfg_t DefaultImsicCfg = '{
        NrHarts     : 32'd4,
        NrSources   : 32'd64,
        NrInptFiles : 32'd3
    };

    // One spare bit per field so out-of-range values can be presented and rejected
    localparam int unsigned UserNrHartsImsicW   = $clog2(DefaultImsicCfg.NrHarts) + 1;
    localparam int unsigned UserNrInptFilesW    = $clog2(DefaultImsicCfg.NrInptFiles) + 1;
    localparam int unsigned UserNrSourcesImsicW = $clog2(DefaultImsicCfg.NrSources) + 1;
    localparam int unsigned NrHartsImsic        = DefaultImsicCfg.NrHarts;

    localparam int unsigned NrMsiReq = 2;

    typedef enum logic [UserNrInptFilesW-1:0] {
        M_FILE  = UserNrInptFilesW'(0),
        S_FILE  = UserNrInptFilesW'(1),
        VS_FILE = UserNrInptFilesW'(2)
    } imsic_file_e;

    typedef struct packed {
        logic [UserNrHartsImsicW-1:0]   hart;
        logic [UserNrInptFilesW-1:0]    file;
        logic [UserNrSourcesImsicW-1:0] ipnum;
    } imsic_msi_req_t;

    typedef struct packed {
        logic [UserNrSourcesImsicW-1:0] setipnum;
        logic [NrHartsImsic-1:0]        imsic_en;
        logic [UserNrInptFilesW-1:0]    select_file;
    } aplic_imsic_channel_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    function automatic logic [NrHartsImsic-1:0] hart_onehot(
        input logic [UserNrHartsImsicW-1:0] hart
    );
        return NrHartsImsic'(1) << hart;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imsic_rr_arbiter.sv
// ============================================================================
// Module      : imsic_rr_arbiter
// Description : Generic N-way round-robin arbiter; the pointer moves past the
//               winner only when the caller signals an accepted handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imsic_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [N-1:0]     w_mask;
    logic [N-1:0]     w_hi;
    logic [N-1:0]     w_pick;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest
    always_comb begin
        w_mask = ~((N'(1) << r_ptr) - N'(1));
        w_hi   = i_req & w_mask;
        w_pick = (|w_hi) ? w_hi : i_req;
        o_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        o_grant = '0;
        if (|i_req) begin
            o_grant = N'(1) << o_idx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_advance && (|i_req)) begin
            r_ptr <= (o_idx == IDX_W'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/imsic_msi_arbiter.sv
// ============================================================================
// Module      : imsic_msi_arbiter
// Description : Round-robin shares the IMSIC setipnum write port between MSI
//               requesters, range-checks each grant and registers one write.
//               Optional drop counter: define IMSIC_ARB_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imsic_msi_arbiter
    import imsic_msi_arbiter_pkg::*;
#(
    parameter int unsigned NR_REQ   = NrMsiReq,
    parameter int unsigned NR_HARTS = DefaultImsicCfg.NrHarts,
    parameter int unsigned NR_SRC   = DefaultImsicCfg.NrSources,
    parameter int unsigned NR_FILES = DefaultImsicCfg.NrInptFiles
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  imsic_msi_req_t [NR_REQ-1:0]         i_req,
    input  logic [NR_REQ-1:0]                   i_req_valid,
    output logic [NR_REQ-1:0]                   o_req_ready,
    output aplic_imsic_channel_t                o_channel,
    input  logic                                i_imsic_stall,
    output logic                                o_drop,
    output logic [15:0]                         o_drop_cnt,
    input  logic                                i_drop_cnt_clr
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    aplic_imsic_channel_t r_channel;
    aplic_imsic_channel_t w_channel_nxt;
    logic                 r_drop;
    logic                 w_drop_nxt;

    logic [NR_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]     w_idx;
    imsic_msi_req_t       w_sel;
    logic                 w_free;
    logic                 w_consume;
    logic                 w_accept;
    logic                 w_in_range;

    imsic_rr_arbiter #(
        .N     (NR_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req_valid),
        .i_advance (w_free),
        .o_grant   (w_grant),
        .o_idx     (w_idx)
    );

    assign w_consume   = (r_state == FULL) && !i_imsic_stall;
    assign w_free      = (r_state == EMPTY) || !i_imsic_stall;
    assign w_accept    = w_free && (|i_req_valid);
    assign o_req_ready = w_free ? w_grant : '0;
    assign w_sel       = i_req[w_idx];

    assign w_in_range = (w_sel.ipnum != '0)
                     && (32'(w_sel.ipnum) < NR_SRC)
                     && (32'(w_sel.file)  < NR_FILES)
                     && (32'(w_sel.hart)  < NR_HARTS);

    // A consume and a reload in the same cycle keep the register FULL
    always_comb begin
        w_state_nxt   = r_state;
        w_channel_nxt = r_channel;
        w_drop_nxt    = 1'b0;
        if (w_consume) begin
            w_state_nxt   = EMPTY;
            w_channel_nxt = '0;
        end
        if (w_accept) begin
            if (w_in_range) begin
                w_state_nxt               = FULL;
                w_channel_nxt.setipnum    = w_sel.ipnum;
                w_channel_nxt.imsic_en    = hart_onehot(w_sel.hart);
                w_channel_nxt.select_file = w_sel.file;
            end else begin
                w_drop_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= EMPTY;
            r_channel <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_channel <= w_channel_nxt;
            r_drop    <= w_drop_nxt;
        end
    end

    assign o_channel = r_channel;
    assign o_drop    = r_drop;

`ifdef IMSIC_ARB_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (i_drop_cnt_clr) begin
            r_drop_cnt <= '0;
        end else if (r_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    logic w_unused_drop_cnt_clr;

    assign w_unused_drop_cnt_clr = i_drop_cnt_clr;
    assign o_drop_cnt            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imsic_msi_arbiter.sv
// ============================================================================
// Module      : tb_imsic_msi_arbiter
// Description : Directed self-checking bench for imsic_msi_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imsic_msi_arbiter;
    import imsic_msi_arbiter_pkg::*;

`ifdef IMSIC_ARB_DROP_CNT_EN
    localparam int unsigned EXP_CNT3 = 3;
`else
    localparam int unsigned EXP_CNT3 = 0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    imsic_msi_req_t [NrMsiReq-1:0] req;
    logic [NrMsiReq-1:0]           req_valid;
    logic [NrMsiReq-1:0]           req_ready;
    aplic_imsic_channel_t          channel;
    logic                          stall;
    logic                          drop;
    logic [15:0]                   drop_cnt;
    logic                          drop_cnt_clr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imsic_msi_arbiter dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .o_channel      (channel),
        .i_imsic_stall  (stall),
        .o_drop         (drop),
        .o_drop_cnt     (drop_cnt),
        .i_drop_cnt_clr (drop_cnt_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic imsic_msi_req_t mk_req(input int h, input int f, input int ip);
        imsic_msi_req_t r;
        r.hart  = UserNrHartsImsicW'(h);
        r.file  = UserNrInptFilesW'(f);
        r.ipnum = UserNrSourcesImsicW'(ip);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        imsic_msi_req_t bad [3];
        rst          = 1'b1;
        req          = '0;
        req_valid    = '0;
        stall        = 1'b0;
        drop_cnt_clr = 1'b0;

        // Reset state
        #2;
        check_val("rst_en",    32'(channel.imsic_en), 32'h0);
        check_val("rst_chan",  32'(channel),          32'h0);
        check_val("rst_ready", 32'(req_ready),        32'h0);
        check_val("rst_drop",  32'(drop),             32'h0);
        check_val("rst_cnt",   32'(drop_cnt),         32'h0);
        step();
        step();
        rst = 1'b0;

        // Single request, one write one cycle later, then EMPTY
        req[0]    = mk_req(1, S_FILE, 5);
        req_valid = 2'b01;
        #1;
        check_val("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check_val("single_ipnum", 32'(channel.setipnum),    32'd5);
        check_val("single_en",    32'(channel.imsic_en),    32'h2);
        check_val("single_file",  32'(channel.select_file), 32'd1);
        check_val("single_drop",  32'(drop),                32'h0);
        step();
        check_val("single_empty", 32'(channel.imsic_en), 32'h0);

        // Both requesters: grants alternate 0,1,0,1 with back-to-back writes
        do_reset();
        req[0]    = mk_req(0, 0, 10);
        req[1]    = mk_req(2, 2, 20);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_val("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clk);
            #1;
            check_val("rr_ipnum", 32'(channel.setipnum), (k % 2 == 0) ? 32'd10 : 32'd20);
            check_val("rr_en",    32'(channel.imsic_en), (k % 2 == 0) ? 32'h1  : 32'h4);
        end
        req_valid = 2'b00;
        step();
        check_val("rr_empty", 32'(channel.imsic_en), 32'h0);

        // Stall while FULL holds the channel and blocks ready
        req[0]    = mk_req(3, 0, 7);
        req_valid = 2'b01;
        #1;
        check_val("stall_ready0", 32'(req_ready), 32'h1);
        step();
        check_val("stall_load", 32'(channel.setipnum), 32'd7);
        req[0] = mk_req(0, 1, 9);
        stall  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("stall_ready", 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
            check_val("stall_ipnum", 32'(channel.setipnum), 32'd7);
            check_val("stall_en",    32'(channel.imsic_en), 32'h8);
        end
        stall = 1'b0;
        #1;
        check_val("stall_release_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check_val("stall_next_ipnum", 32'(channel.setipnum),    32'd9);
        check_val("stall_next_en",    32'(channel.imsic_en),    32'h1);
        check_val("stall_next_file",  32'(channel.select_file), 32'd1);
        step();
        check_val("stall_empty", 32'(channel.imsic_en), 32'h0);

        // Out-of-range requests are accepted and dropped
        bad[0]    = mk_req(0, 0, 0);
        bad[1]    = mk_req(0, 0, 64);
        bad[2]    = mk_req(0, 3, 5);
        req_valid = 2'b01;
        for (int k = 0; k < 3; k++) begin
            req[0] = bad[k];
            #1;
            check_val("drop_ready", 32'(req_ready), 32'h1);
            @(posedge clk);
            #1;
            check_val("drop_pulse", 32'(drop),             32'h1);
            check_val("drop_en",    32'(channel.imsic_en), 32'h0);
        end
        req_valid = 2'b00;
        step();
        check_val("drop_idle", 32'(drop),     32'h0);
        check_val("drop_cnt3", 32'(drop_cnt), EXP_CNT3);
        drop_cnt_clr = 1'b1;
        step();
        drop_cnt_clr = 1'b0;
        check_val("drop_clr", 32'(drop_cnt), 32'h0);

        // Async reset while FULL discards the entry and rewinds the pointer
        req[0]    = mk_req(2, 2, 33);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        stall     = 1'b1;
        check_val("arst_full_en", 32'(channel.imsic_en), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_en",   32'(channel.imsic_en), 32'h0);
        check_val("arst_chan", 32'(channel),          32'h0);
        rst       = 1'b0;
        stall     = 1'b0;
        req[0]    = mk_req(1, 0, 11);
        req[1]    = mk_req(3, 1, 12);
        req_valid = 2'b11;
        #1;
        check_val("arst_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check_val("arst_first_ipnum", 32'(channel.setipnum), 32'd11);
        step();

`ifdef IMSIC_ARB_DROP_CNT_EN
        // Counter saturation, then clear beats a simultaneous increment
        req[0]    = mk_req(0, 0, 0);
        req_valid = 2'b01;
        repeat (65537) @(posedge clk);
        #1;
        req_valid = 2'b00;
        step();
        check_val("sat_cnt", 32'(drop_cnt), 32'hFFFF);
        req_valid = 2'b01;
        step();
        req_valid    = 2'b00;
        drop_cnt_clr = 1'b1;
        check_val("sat_drop_high", 32'(drop), 32'h1);
        step();
        drop_cnt_clr = 1'b0;
        check_val("sat_clr_priority", 32'(drop_cnt), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
